dual_issue_scheduler: RTL and testbench
=======================================

DUAL_ISSUE_SCHEDULER -- requirements
Module: dual_issue_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: port clk, posedge; port reset, synchronous, active-high.
REQ-002 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- fetch_valid  in  1  instruction pair offered
- fetch_ready  out  1  scheduler accepts pair this cycle
- fetch_inst0  in  32  older instruction
- fetch_inst1  in  32  younger instruction
- fetch_pc  in  6  PC of fetch_inst0; inst1 is at fetch_pc+1
- flush  in  1  taken branch/jump resolved; discard pending work
- stall_in  in  1  downstream cannot take an issue this cycle
- issue0_valid  out  1  slot-0 issue valid
- issue0_inst  out  32  slot-0 instruction
- issue0_pc  out  6  slot-0 PC
- issue1_valid  out  1  slot-1 issue valid
- issue1_inst  out  32  slot-1 instruction
- issue1_pc  out  6  slot-1 PC

Function
REQ-003 States SHALL be EMPTY (no pair buffered), FULL (pair buffered, both pending), SECOND (only the younger instruction pending).
REQ-004 A pair SHALL be captured when fetch_valid & fetch_ready at a clk edge; state becomes FULL; latency from accept to issue is exactly 1 cycle.
REQ-005 fetch_ready SHALL be the logical OR of EMPTY, FULL & !conflict & !stall_in, and SECOND & !stall_in; it SHALL be forced to 0 when flush or reset is high.
REQ-006 Per-slot decode: opcode 0x00 with funct 0x08 (jr) reads rs and writes nothing. Opcode 0x00 otherwise reads rs and rt and writes rd. Opcode 0x03 (jal) writes r31. Opcode 0x02 (j) reads and writes nothing. Opcodes 0x04/0x05 (beq/bne) read rs and rt. Opcode 0x2B (sw) reads rs and rt. Opcode 0x23 (lw) reads rs and writes rt. Any other opcode reads rs and writes rt.
REQ-007 conflict SHALL be high if any of these holds:
- a RAW hazard: inst1 reads inst0's destination;
- a WAW hazard: equal destinations;
- both instructions are lw/sw;
- inst0 is a control instruction (j, jal, jr, beq, bne).
Register 0 SHALL never cause a RAW or WAW hazard.
REQ-008 In FULL with no conflict, both issue valids SHALL be 1, carrying inst0/pc and inst1/pc+1. On !stall_in, both retire.
REQ-009 In FULL with a conflict, only issue0_valid SHALL be 1. On !stall_in the state SHALL go to SECOND.
REQ-010 In SECOND, issue0 SHALL carry inst1 at pc+1, and issue1_valid SHALL be 0. On !stall_in the state returns to EMPTY, or to FULL if a new pair is accepted the same cycle.
REQ-011 While stall_in is high, state, buffer and outputs SHALL hold unchanged.
REQ-012 flush SHALL take priority over all other events: next state EMPTY, both valids 0 the next cycle, and no pair accepted in the flush cycle.
REQ-013 PC arithmetic SHALL be 6-bit modulo 64 (pc 63 gives a slot-1 PC of 0).
REQ-014 Issue outputs SHALL be driven combinationally from the registered buffer and state only, with no combinational path from fetch_* inputs.

Reset
REQ-015 On reset the state SHALL be EMPTY, the buffer cleared to 0, both issue valids 0, and issue inst/pc outputs 0.
REQ-016 Reset SHALL abort a buffered or split pair mid-operation, with no issue in the following cycle.

Configuration
REQ-017 With macro SCHED_PERF_CNT_EN defined, the block SHALL add outputs dual_cnt[15:0] and split_cnt[15:0].
- dual_cnt increments on each dual retirement.
- split_cnt increments on each FULL-to-SECOND transition.
- Both counters saturate at 0xFFFF and clear on reset.
REQ-018 Without SCHED_PERF_CNT_EN, these ports and counters SHALL be absent, and behaviour is otherwise identical.

Structure
REQ-019 Package sched_pkg SHALL hold:
- opcode/funct constants (0x00, 0x02, 0x03, 0x04, 0x05, 0x23, 0x2B, funct 0x08);
- the state enum;
- the register-index width (5) and PC width (6).
REQ-020 Sub-module sched_decode SHALL be combinational, producing dest, dest_valid, reads_rs, reads_rt, is_mem and is_ctrl; it SHALL be instantiated once per slot.

Verification
REQ-021 Independent pair (add r1,r2,r3 then add r4,r5,r6) at pc 10 -> next cycle both valids 1 with pcs 10/11, and fetch_ready 1 for back-to-back accept.
REQ-022 RAW pair (add r1,.. then sub r7,r1,r2) -> cycle 1: issue0 only; cycle 2: issue0 carries sub at pc+1; pair targeting r0 as dest -> dual issue.
REQ-023 Pair lw then sw, and pair beq then add -> both split over two cycles; split_cnt increments by 1 each when SCHED_PERF_CNT_EN is defined.
REQ-024 stall_in held 3 cycles in FULL and in SECOND -> outputs stable, fetch_ready 0, then resume exactly once.
REQ-025 flush asserted in SECOND, and reset asserted in FULL -> next cycle valids 0, EMPTY, fetch_pc 63 pair then issues pcs 63/0.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared constants and types for the dual-issue scheduler and its per-slot decoder.
package sched_pkg;

    localparam int REG_W  = 5;
    localparam int PC_W   = 6;
    localparam int INST_W = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    localparam logic [REG_W-1:0] REG_LINK = 5'd31;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_SECOND = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sched_decode.sv
// Combinational per-slot decode: destination register, source usage and instruction class.
module sched_decode
    import sched_pkg::*;
(
    input  logic [INST_W-1:0] i_inst,
    output logic [REG_W-1:0]  o_dest,
    output logic              o_dest_valid,
    output logic              o_reads_rs,
    output logic              o_reads_rt,
    output logic              o_is_mem,
    output logic              o_is_ctrl
);

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [REG_W-1:0] w_rt;
    logic [REG_W-1:0] w_rd;
    logic             w_unused_shamt;

    assign w_op           = i_inst[31:26];
    assign w_funct        = i_inst[5:0];
    assign w_rt           = i_inst[20:16];
    assign w_rd           = i_inst[15:11];
    assign w_unused_shamt = ^i_inst[10:6];

    always_comb begin
        o_dest       = w_rt;
        o_dest_valid = 1'b1;
        o_reads_rs   = 1'b1;
        o_reads_rt   = 1'b0;
        o_is_mem     = 1'b0;
        o_is_ctrl    = 1'b0;
        case (w_op)
            OP_SPECIAL: begin
                if (w_funct == FUNCT_JR) begin
                    o_dest_valid = 1'b0;
                    o_is_ctrl    = 1'b1;
                end else begin
                    o_dest     = w_rd;
                    o_reads_rt = 1'b1;
                end
            end
            OP_JAL: begin
                o_dest     = REG_LINK;
                o_reads_rs = 1'b0;
                o_is_ctrl  = 1'b1;
            end
            OP_J: begin
                o_dest_valid = 1'b0;
                o_reads_rs   = 1'b0;
                o_is_ctrl    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_dest_valid = 1'b0;
                o_reads_rt   = 1'b1;
                o_is_ctrl    = 1'b1;
            end
            OP_SW: begin
                o_dest_valid = 1'b0;
                o_reads_rt   = 1'b1;
                o_is_mem     = 1'b1;
            end
            OP_LW: begin
                o_is_mem = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Two-slot in-order issue scheduler with pair hazard detection.
// Optional performance counters are enabled with macro SCHED_PERF_CNT_EN.
//
// state     | meaning
// ST_EMPTY  | no pair buffered
// ST_FULL   | pair buffered, both instructions pending
// ST_SECOND | only the younger instruction pending
module dual_issue_scheduler
    import sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [INST_W-1:0] fetch_inst0,
    input  logic [INST_W-1:0] fetch_inst1,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              flush,
    input  logic              stall_in,
    output logic              issue0_valid,
    output logic [INST_W-1:0] issue0_inst,
    output logic [PC_W-1:0]   issue0_pc,
    output logic              issue1_valid,
    output logic [INST_W-1:0] issue1_inst,
`ifdef SCHED_PERF_CNT_EN
    output logic [PC_W-1:0]   issue1_pc,
    output logic [15:0]       dual_cnt,
    output logic [15:0]       split_cnt
`else
    output logic [PC_W-1:0]   issue1_pc
`endif
);

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    logic [INST_W-1:0] r_inst0;
    logic [INST_W-1:0] r_inst1;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc1;

    logic [REG_W-1:0]  w_dest0, w_dest1;
    logic              w_dv0, w_dv1;
    logic              w_rs0, w_rs1;
    logic              w_rt0, w_rt1;
    logic              w_mem0, w_mem1;
    logic              w_ctrl0, w_ctrl1;
    logic              w_raw, w_waw, w_conflict;
    logic              w_accept;
    logic              w_unused_dec;

    sched_decode u_dec0 (
        .i_inst       (r_inst0),
        .o_dest       (w_dest0),
        .o_dest_valid (w_dv0),
        .o_reads_rs   (w_rs0),
        .o_reads_rt   (w_rt0),
        .o_is_mem     (w_mem0),
        .o_is_ctrl    (w_ctrl0)
    );

    sched_decode u_dec1 (
        .i_inst       (r_inst1),
        .o_dest       (w_dest1),
        .o_dest_valid (w_dv1),
        .o_reads_rs   (w_rs1),
        .o_reads_rt   (w_rt1),
        .o_is_mem     (w_mem1),
        .o_is_ctrl    (w_ctrl1)
    );

    // Only the younger slot's sources and the older slot's class matter for pairing.
    assign w_unused_dec = w_rs0 ^ w_rt0 ^ w_ctrl1;

    assign w_pc1 = r_pc + PC_W'(1);

    assign w_raw = w_dv0 && (w_dest0 != '0) &&
                   ((w_rs1 && (r_inst1[25:21] == w_dest0)) ||
                    (w_rt1 && (r_inst1[20:16] == w_dest0)));
    assign w_waw = w_dv0 && w_dv1 && (w_dest0 != '0) && (w_dest0 == w_dest1);
    assign w_conflict = w_raw || w_waw || (w_mem0 && w_mem1) || w_ctrl0;

    assign fetch_ready = !flush && !reset &&
                         ((r_state == ST_EMPTY) ||
                          ((r_state == ST_FULL) && !w_conflict && !stall_in) ||
                          ((r_state == ST_SECOND) && !stall_in));
    assign w_accept = fetch_valid && fetch_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) w_state_nxt = ST_FULL;
                end
                ST_FULL: begin
                    if (!stall_in) begin
                        if (w_conflict)    w_state_nxt = ST_SECOND;
                        else if (w_accept) w_state_nxt = ST_FULL;
                        else               w_state_nxt = ST_EMPTY;
                    end
                end
                ST_SECOND: begin
                    if (!stall_in) w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        issue0_valid = 1'b0;
        issue0_inst  = '0;
        issue0_pc    = '0;
        issue1_valid = 1'b0;
        issue1_inst  = '0;
        issue1_pc    = '0;
        case (r_state)
            ST_FULL: begin
                issue0_valid = 1'b1;
                issue0_inst  = r_inst0;
                issue0_pc    = r_pc;
                issue1_valid = !w_conflict;
                issue1_inst  = r_inst1;
                issue1_pc    = w_pc1;
            end
            ST_SECOND: begin
                issue0_valid = 1'b1;
                issue0_inst  = r_inst1;
                issue0_pc    = w_pc1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inst0 <= '0;
            r_inst1 <= '0;
            r_pc    <= '0;
        end else if (w_accept) begin
            r_inst0 <= fetch_inst0;
            r_inst1 <= fetch_inst1;
            r_pc    <= fetch_pc;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic w_dual_retire;
    logic w_split;

    assign w_dual_retire = (r_state == ST_FULL) && !w_conflict && !stall_in && !flush;
    assign w_split       = (r_state == ST_FULL) && (w_state_nxt == ST_SECOND);

    always_ff @(posedge clk) begin
        if (reset) begin
            dual_cnt  <= '0;
            split_cnt <= '0;
        end else begin
            if (w_dual_retire && (dual_cnt != 16'hFFFF))  dual_cnt  <= dual_cnt + 16'd1;
            if (w_split && (split_cnt != 16'hFFFF))       split_cnt <= split_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench: directed pair table, multi-cycle corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_inst0, fetch_inst1;
    logic [5:0]  fetch_pc;
    logic        flush, stall_in;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_inst, issue1_inst;
    logic [5:0]  issue0_pc, issue1_pc;
`ifdef SCHED_PERF_CNT_EN
    logic [15:0] dual_cnt, split_cnt;
`endif

    dual_issue_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .fetch_inst0  (fetch_inst0),
        .fetch_inst1  (fetch_inst1),
        .fetch_pc     (fetch_pc),
        .flush        (flush),
        .stall_in     (stall_in),
        .issue0_valid (issue0_valid),
        .issue0_inst  (issue0_inst),
        .issue0_pc    (issue0_pc),
        .issue1_valid (issue1_valid),
        .issue1_inst  (issue1_inst),
`ifdef SCHED_PERF_CNT_EN
        .issue1_pc    (issue1_pc),
        .dual_cnt     (dual_cnt),
        .split_cnt    (split_cnt)
`else
        .issue1_pc    (issue1_pc)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pending instructions in program order.
    logic [31:0] q_inst[$];
    logic [5:0]  q_pc[$];
    int          m_dual  = 0;
    int          m_split = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
        itype = {op, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    // Register written by an instruction; 0 means none (r0 never creates a hazard).
    function automatic int dest_of(input logic [31:0] i);
        logic [5:0] op = i[31:26];
        if (op == 6'h00) return (i[5:0] == 6'h08) ? 0 : int'(i[15:11]);
        if (op == 6'h03) return 31;
        if (op == 6'h02 || op == 6'h04 || op == 6'h05 || op == 6'h2B) return 0;
        return int'(i[20:16]);
    endfunction

    function automatic bit reads_reg(input logic [31:0] i, input int r);
        logic [5:0] op = i[31:26];
        bit rs_used = !(op == 6'h02 || op == 6'h03);
        bit rt_used = (op == 6'h00 && i[5:0] != 6'h08) || op == 6'h04 || op == 6'h05 || op == 6'h2B;
        return (rs_used && int'(i[25:21]) == r) || (rt_used && int'(i[20:16]) == r);
    endfunction

    function automatic bit pair_conflict(input logic [31:0] a, input logic [31:0] b);
        int  d0 = dest_of(a);
        bit  mem_a = (a[31:26] == 6'h23) || (a[31:26] == 6'h2B);
        bit  mem_b = (b[31:26] == 6'h23) || (b[31:26] == 6'h2B);
        bit  ctrl  = (a[31:26] inside {6'h02, 6'h03, 6'h04, 6'h05}) ||
                     (a[31:26] == 6'h00 && a[5:0] == 6'h08);
        return (d0 != 0 && reads_reg(b, d0)) || (d0 != 0 && d0 == dest_of(b)) ||
               (mem_a && mem_b) || ctrl;
    endfunction

    // One cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic step(input bit fv, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [5:0] pc, input bit fl, input bit st);
        bit conf, e_rdy, e_v0, e_v1;
        int pops;
        @(negedge clk);
        reset = 1'b0; fetch_valid = fv; fetch_inst0 = i0; fetch_inst1 = i1;
        fetch_pc = pc; flush = fl; stall_in = st;
        #1;
        conf  = (q_inst.size() == 2) && pair_conflict(q_inst[0], q_inst[1]);
        e_rdy = !fl && (q_inst.size() == 0 || (!st && (q_inst.size() == 1 || !conf)));
        e_v0  = q_inst.size() > 0;
        e_v1  = q_inst.size() == 2 && !conf;
        chk("fetch_ready", 32'(fetch_ready), 32'(e_rdy));
        chk("issue0_valid", 32'(issue0_valid), 32'(e_v0));
        chk("issue1_valid", 32'(issue1_valid), 32'(e_v1));
        if (e_v0) begin
            chk("issue0_inst", issue0_inst, q_inst[0]);
            chk("issue0_pc", 32'(issue0_pc), 32'(q_pc[0]));
        end
        if (e_v1) begin
            chk("issue1_inst", issue1_inst, q_inst[1]);
            chk("issue1_pc", 32'(issue1_pc), 32'(q_pc[1]));
        end
        if (fl) begin
            q_inst.delete(); q_pc.delete();
        end else begin
            if (!st) begin
                if (e_v1) m_dual++;
                if (q_inst.size() == 2 && conf) m_split++;
                pops = e_v1 ? 2 : (e_v0 ? 1 : 0);
                repeat (pops) begin
                    void'(q_inst.pop_front()); void'(q_pc.pop_front());
                end
            end
            if (fv && e_rdy) begin
                q_inst.push_back(i0); q_pc.push_back(pc);
                q_inst.push_back(i1); q_pc.push_back(pc + 6'd1);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
    endtask

    // Reset is held across exactly one posedge; a pair is offered to show it is refused.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; fetch_valid = 1'b1; flush = 1'b0; stall_in = 1'b0;
        #1;
        chk("ready_in_reset", 32'(fetch_ready), 32'd0);
        q_inst.delete(); q_pc.delete();
        m_dual = 0; m_split = 0;
    endtask

    task automatic chk_counters();
`ifdef SCHED_PERF_CNT_EN
        chk("dual_cnt", 32'(dual_cnt), 32'(m_dual));
        chk("split_cnt", 32'(split_cnt), 32'(m_split));
`endif
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops[9];
        int k;
        ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B};
        k = $urandom_range(0, 9);
        if (k == 9) return rtype($urandom_range(0, 7), 0, 0, 6'h08);
        if (k == 8) return itype(6'h08, $urandom_range(0, 7), $urandom_range(0, 7));
        if (ops[k] == 6'h00)
            return rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h20);
        return itype(ops[k], $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    typedef struct {
        logic [31:0] i0;
        logic [31:0] i1;
        logic [5:0]  pc;
        bit          dual;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] add_a, add_b, sub_raw;
        reset = 1'b1; fetch_valid = 1'b0; fetch_inst0 = '0; fetch_inst1 = '0;
        fetch_pc = '0; flush = 1'b0; stall_in = 1'b0;

        add_a   = rtype(2, 3, 1, 6'h20);
        add_b   = rtype(5, 6, 4, 6'h20);
        sub_raw = rtype(1, 2, 7, 6'h22);
        vecs[0]  = '{add_a, add_b, 6'd10, 1'b1};
        vecs[1]  = '{add_a, sub_raw, 6'd12, 1'b0};
        vecs[2]  = '{rtype(2, 3, 0, 6'h20), rtype(0, 5, 4, 6'h20), 6'd14, 1'b1};
        vecs[3]  = '{itype(6'h23, 2, 1), itype(6'h2B, 4, 3), 6'd16, 1'b0};
        vecs[4]  = '{itype(6'h04, 1, 2), add_b, 6'd18, 1'b0};
        vecs[5]  = '{add_a, rtype(5, 6, 1, 6'h20), 6'd20, 1'b0};
        vecs[6]  = '{add_a, add_b, 6'd63, 1'b1};
        vecs[7]  = '{rtype(31, 0, 0, 6'h08), add_b, 6'd22, 1'b0};
        vecs[8]  = '{itype(6'h08, 1, 5), itype(6'h23, 5, 6), 6'd24, 1'b0};
        vecs[9]  = '{itype(6'h23, 2, 1), rtype(3, 4, 2, 6'h20), 6'd26, 1'b1};
        vecs[10] = '{itype(6'h2B, 2, 1), rtype(5, 6, 1, 6'h20), 6'd28, 1'b1};
        vecs[11] = '{add_a, itype(6'h03, 0, 0), 6'd30, 1'b1};

        do_reset();
        @(negedge clk); reset = 1'b0; fetch_valid = 1'b0;
        #1;
        chk("rst_v0", 32'(issue0_valid), 32'd0);
        chk("rst_v1", 32'(issue1_valid), 32'd0);
        chk("rst_inst0", issue0_inst, 32'd0);
        chk("rst_pc0", 32'(issue0_pc), 32'd0);
        chk("rst_inst1", issue1_inst, 32'd0);
        chk("rst_pc1", 32'(issue1_pc), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);

        foreach (vecs[n]) begin
            step(1'b1, vecs[n].i0, vecs[n].i1, vecs[n].pc, 1'b0, 1'b0);
            step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
            chk("tbl_v0", 32'(issue0_valid), 32'd1);
            chk("tbl_inst0", issue0_inst, vecs[n].i0);
            chk("tbl_pc0", 32'(issue0_pc), 32'(vecs[n].pc));
            chk("tbl_dual", 32'(issue1_valid), 32'(vecs[n].dual));
            if (vecs[n].dual) begin
                chk("tbl_pc1", 32'(issue1_pc), 32'(6'(vecs[n].pc + 6'd1)));
            end else begin
                step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
                chk("tbl_second_inst", issue0_inst, vecs[n].i1);
                chk("tbl_second_pc", 32'(issue0_pc), 32'(6'(vecs[n].pc + 6'd1)));
                chk("tbl_second_v1", 32'(issue1_valid), 32'd0);
            end
            step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
            chk("tbl_empty", 32'(issue0_valid | issue1_valid), 32'd0);
        end
        chk_counters();

        // Back-to-back accept of independent pairs.
        step(1'b1, add_a, add_b, 6'd10, 1'b0, 1'b0);
        step(1'b1, add_b, add_a, 6'd40, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        idle(1);

        // Stall for 3 cycles in FULL (conflict pair) and again in SECOND.
        step(1'b1, add_a, sub_raw, 6'd5, 1'b0, 1'b0);
        repeat (3) step(1'b1, add_b, add_a, 6'd50, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        repeat (3) step(1'b1, add_b, add_a, 6'd50, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        idle(2);

        // Stall in FULL on a dual pair, then resume with a same-cycle accept.
        step(1'b1, add_a, add_b, 6'd7, 1'b0, 1'b0);
        repeat (3) step(1'b1, add_b, add_a, 6'd60, 1'b0, 1'b1);
        step(1'b1, add_b, add_a, 6'd60, 1'b0, 1'b0);
        idle(2);

        // Flush in SECOND, then a pair at pc 63 wraps slot 1 to pc 0.
        step(1'b1, add_a, sub_raw, 6'd8, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        step(1'b1, add_b, add_a, 6'd33, 1'b1, 1'b0);
        step(1'b1, add_a, add_b, 6'd63, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("wrap_pc0", 32'(issue0_pc), 32'd63);
        chk("wrap_pc1", 32'(issue1_pc), 32'd0);
        idle(1);

        // Reset while FULL aborts the pair.
        step(1'b1, add_a, add_b, 6'd3, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(issue0_valid | issue1_valid), 32'd0);
        step(1'b1, add_a, add_b, 6'd63, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("rst_wrap_pc1", 32'(issue1_pc), 32'd0);
        idle(1);
        chk_counters();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, rand_inst(), rand_inst(), 6'($urandom_range(0, 63)),
                     $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
            end
        end
        idle(3);
        chk_counters();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
